// File: rtl/noc_rr_arbiter_param.sv
// Wormhole packet arbiter for a NoC router output port: N requesters, fixed-priority or
// round-robin selection, lock held head-to-tail, owner-abandon timeout.
//
// state  | meaning
// IDLE   | no owner; any request is granted on the next edge
// LOCKED | one port owns the output until its tail flit transfers or it times out
module noc_rr_arbiter_param #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16,
    parameter int ID_W    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    tail,
    input  logic            mode,
    input  logic            out_ready,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id,
    output logic            xfer,
    output logic            timeout_err
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N - 1);
    localparam logic [N-1:0]     ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [N-1:0]     grant_nxt;
    logic             valid_nxt;
    logic [ID_W-1:0]  id_nxt;
    logic [ID_W-1:0]  ptr, ptr_nxt;
    logic [CNT_W-1:0] idle_cnt, cnt_nxt;
    logic             terr_nxt;

    logic             owner_req;
    logic             owner_tail;
    logic             release_pkt;
    logic             timeout_hit;
    logic [ID_W-1:0]  ptr_rel;
    logic [ID_W-1:0]  arb_start;
    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic [N-1:0]     win_onehot;
    int               idx;

    assign owner_req   = req[grant_id];
    assign owner_tail  = tail[grant_id];
    assign xfer        = grant_valid & owner_req & out_ready;
    assign release_pkt = xfer & owner_tail;
    assign timeout_hit = (TIMEOUT > 0) && grant_valid && !owner_req && (idle_cnt == CNT_LAST);
    assign ptr_rel     = (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;

    // On release the search already starts past the old owner, so a back-to-back winner
    // is chosen in the same cycle and the releasing port ends up with lowest RR priority.
    assign arb_start   = (state == LOCKED) ? ptr_rel : ptr;
    assign win_onehot  = ONE_HOT0 << win_id;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = mode ? (int'(arb_start) + i) : i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!win_found && req[ID_W'(idx)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        valid_nxt = grant_valid;
        id_nxt    = grant_id;
        ptr_nxt   = ptr;
        cnt_nxt   = idle_cnt;
        terr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (win_found) begin
                    state_nxt = LOCKED;
                    grant_nxt = win_onehot;
                    valid_nxt = 1'b1;
                    id_nxt    = win_id;
                end
            end
            LOCKED: begin
                if (release_pkt || timeout_hit) begin
                    ptr_nxt  = ptr_rel;
                    cnt_nxt  = '0;
                    terr_nxt = timeout_hit;
                    if (win_found) begin
                        grant_nxt = win_onehot;
                        id_nxt    = win_id;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        valid_nxt = 1'b0;
                        id_nxt    = '0;
                    end
                end else if (owner_req) begin
                    cnt_nxt = '0;
                end else if (idle_cnt != CNT_MAX) begin
                    // saturates so a disabled timeout never wraps into a false match
                    cnt_nxt = idle_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                valid_nxt = 1'b0;
                id_nxt    = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr         <= '0;
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_valid <= valid_nxt;
            grant_id    <= id_nxt;
            ptr         <= ptr_nxt;
            idle_cnt    <= cnt_nxt;
            timeout_err <= terr_nxt;
        end
    end

endmodule

// File: tb/tb_noc_rr_arbiter_param.sv
// Directed bench for noc_rr_arbiter_param (N=4, TIMEOUT=16) with hand-computed expectations.
module tb_noc_rr_arbiter_param;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;
    localparam int ID_W    = $clog2(N);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    tail;
    logic            mode;
    logic            out_ready;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
    logic            xfer;
    logic            timeout_err;

    int checks = 0;
    int fails  = 0;

    noc_rr_arbiter_param #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .tail        (tail),
        .mode        (mode),
        .out_ready   (out_ready),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .xfer        (xfer),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_owner(input string tag, input int id);
        chk({tag, "_valid"}, 32'(grant_valid), 32'd1);
        chk({tag, "_id"},    32'(grant_id),    32'(id));
        chk({tag, "_grant"}, 32'(grant),       32'(1) << id);
    endtask

    task automatic chk_unlocked(input string tag);
        chk({tag, "_valid"}, 32'(grant_valid), 32'd0);
        chk({tag, "_id"},    32'(grant_id),    32'd0);
        chk({tag, "_grant"}, 32'(grant),       32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        tail      = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int   exp_t1[5] = '{0, 1, 2, 3, 0};
    logic rdy_t3[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic tl_t3[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic saw_terr;

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        tail      = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        #3;
        chk_unlocked("reset");
        chk("reset_terr", 32'(timeout_err), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_unlocked("idle_noreq");

        // round robin, single-flit packets, all ports requesting
        mode = 1'b1;
        req  = 4'b1111;
        tail = 4'b1111;
        #1;
        chk("t1_pre_xfer", 32'(xfer), 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk_owner("t1_seq", exp_t1[k]);
            chk("t1_xfer", 32'(xfer), 32'd1);
            if (k < 4) tick();
        end

        // fixed priority, 3-flit packets from ports 1 and 3
        do_reset();
        mode = 1'b0;
        req  = 4'b1010;
        tail = 4'b0000;
        tick();
        chk_owner("t2_lock", 1);
        tail = 4'b1000;
        #1;
        chk("t2_xfer1", 32'(xfer), 32'd1);
        tick();
        chk_owner("t2_flit1", 1);
        tail = 4'b0000;
        tick();
        chk_owner("t2_flit2", 1);
        tail = 4'b0010;
        tick();
        chk_owner("t2_regrant", 1);
        mode = 1'b1;
        #1;
        chk_owner("t2_modechg", 1);
        tick();
        chk_owner("t2_rr_after", 3);

        // backpressure while port 2 owns the output
        do_reset();
        mode = 1'b1;
        req  = 4'b0100;
        tail = 4'b0000;
        tick();
        chk_owner("t3_lock", 2);
        req = 4'b1100;
        for (int k = 0; k < 5; k++) begin
            out_ready = rdy_t3[k];
            tail      = tl_t3[k] ? 4'b0100 : 4'b0000;
            #1;
            chk("t3_xfer", 32'(xfer), 32'(rdy_t3[k]));
            tick();
            if (k < 4) chk_owner("t3_hold", 2);
            else       chk_owner("t3_next", 3);
        end
        out_ready = 1'b1;

        // owner abandons: timeout after 16 idle cycles
        do_reset();
        mode = 1'b1;
        req  = 4'b0011;
        tail = 4'b0000;
        tick();
        chk_owner("t4_lock", 0);
        chk("t4_xfer", 32'(xfer), 32'd1);
        tick();
        req = 4'b0010;
        #1;
        chk("t4_idle_xfer", 32'(xfer), 32'd0);
        for (int k = 0; k < 15; k++) tick();
        chk("t4_terr_early", 32'(timeout_err), 32'd0);
        chk_owner("t4_still", 0);
        tick();
        chk("t4_terr", 32'(timeout_err), 32'd1);
        chk_owner("t4_new", 1);
        tick();
        chk("t4_terr_pulse", 32'(timeout_err), 32'd0);
        chk_owner("t4_new_hold", 1);

        // counter clears when the owner requests again
        do_reset();
        mode     = 1'b1;
        req      = 4'b0001;
        tail     = 4'b0000;
        saw_terr = 1'b0;
        tick();
        chk_owner("t5_lock", 0);
        req = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            saw_terr = saw_terr | timeout_err;
        end
        req = 4'b0001;
        #1;
        chk("t5_xfer", 32'(xfer), 32'd1);
        tick();
        saw_terr = saw_terr | timeout_err;
        req = 4'b0000;
        for (int k = 0; k < 15; k++) begin
            tick();
            saw_terr = saw_terr | timeout_err;
        end
        chk("t5_no_terr", 32'(saw_terr), 32'd0);
        chk_owner("t5_still", 0);
        tick();
        chk("t5_terr", 32'(timeout_err), 32'd1);
        chk_unlocked("t5_to_idle");
        tick();
        chk("t5_terr_pulse", 32'(timeout_err), 32'd0);

        // asynchronous reset mid-packet
        do_reset();
        mode = 1'b1;
        req  = 4'b1000;
        tail = 4'b0000;
        tick();
        chk_owner("t6_lock", 3);
        chk("t6_xfer", 32'(xfer), 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_unlocked("t6_async");
        chk("t6_terr", 32'(timeout_err), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk_unlocked("t6_released");
        tick();
        chk_owner("t6_regrant", 3);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
